mux_sel_arbiter: RTL
====================

Name: mux_sel_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared 4:1, 32-bit datapath multiplexer.
- Accepts up to four requesters, such as a shared memory/bus port or a writeback source.
- Grants exactly one requester at a time and holds the grant until that requester signals completion.
- Drives the mux select code with a registered output, so the select never glitches.

Parameters:
- NUM_REQ, 4: number of requesters; fixed at 4 to match the 2-bit select. Any other value is a compile-time error.
- TIMEOUT_CYCLES, 16: maximum grant hold in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range is 2 to 255.

Ports:
- clk  input  1  system clock; all logic acts on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  4  request per requester; bit n is requester n. Level-sensitive.
- done_i  input  1  completion strobe from the currently granted requester. Ignored when no grant is active.
- gnt_o  output  4  one-hot grant, registered; all zeros when idle.
- sel_o  output  2  binary index of the granted requester; connects to the mux sel_i.
- busy_o  output  1  high while any grant is active.
- timeout_o  output  1  one-cycle pulse on a forced release. Tied to 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: synchronous. On any clock edge with rst=1:
  - gnt_o=0, sel_o=0, busy_o=0, timeout_o=0.
  - State goes to IDLE.
  - Last-served pointer last=3, so requester 0 has the highest priority first.
  - Hold counter is cleared.
- Reset mid-grant: drops the grant on the next edge. No done_i is required.
- State IDLE (busy_o=0, gnt_o=0):
  - If req_i != 0, go to GRANT on the next edge.
  - The winner is the first set bit of req_i, searched in the order last+1, last+2, last+3, last (mod 4).
  - On that edge: gnt_o=1<<winner, sel_o=winner, busy_o=1.
  - Latency from req_i asserted to gnt_o is 1 cycle.
- State GRANT:
  - gnt_o and sel_o hold constant.
  - Deasserting req_i does not release the grant. Only done_i (or a timeout) releases it.
- On done_i=1 in GRANT:
  - last is set to the current winner.
  - Arbitration reruns in the same cycle using the current req_i and the updated last. The finishing requester therefore has the lowest priority.
  - If any request is pending, the next grant appears on the next edge with no idle bubble. busy_o stays 1.
  - If only the finishing requester still requests, it is re-granted.
  - If req_i=0, go to IDLE: gnt_o=0, busy_o=0.
- sel_o in IDLE holds its last granted value; it does not return to 0. After reset it is 0.
- Simultaneous requests in IDLE are resolved purely by rotating priority from last.
- done_i together with a new request arriving in the same cycle: the new request takes part in that cycle's arbitration.
- Invariants:
  - gnt_o is always zero or one-hot.
  - When busy_o=1, gnt_o[sel_o]=1.
  - busy_o = |gnt_o.
- Hold counter (8-bit):
  - Clears on every new grant.
  - Increments each cycle in GRANT.
  - Saturates at 255.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When the hold counter reaches TIMEOUT_CYCLES-1 in GRANT and done_i=0, the block performs a forced release on the next edge.
  - The forced release is identical to a done_i release: last is updated and re-arbitration takes place.
  - timeout_o pulses 1 for exactly that one cycle, aligned with the new gnt_o value.
  - If done_i and the timeout occur in the same cycle, done_i wins and timeout_o stays 0.
- Not defined:
  - No timeout logic is built; a grant holds indefinitely.
  - timeout_o is constant 0. TIMEOUT_CYCLES is ignored.

Test Plan:
1. Assert rst for 2 cycles with req_i=4'b1111, then deassert. Required:
   - During reset: gnt_o=0, sel_o=0, busy_o=0.
   - First cycle after reset: gnt_o=0001, sel_o=0.
2. Hold req_i=1111 and pulse done_i every 3rd cycle. Required:
   - Grants rotate 0001→0010→0100→1000→0001.
   - No cycle with busy_o=0 between grants.
3. Grant requester 2 (req_i=0100), then drop req_i to 0000 without done_i for 5 cycles, then pulse done_i. Required:
   - gnt_o=0100 held for all 5 cycles.
   - After done_i: gnt_o=0000, busy_o=0, sel_o stays 2.
4. Requester 1 is granted and last=1. Pulse done_i while req_i=1011. Required: next grant is 1000 (requester 3), not requester 1.
5. Hold only req_i=0001 and pulse done_i twice. Required: requester 0 is re-granted each time and busy_o stays 1 throughout.
6. With ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, hold req_i=0011 with done_i=0. Required:
   - Grant 0001 for 4 cycles, then gnt_o=0010 with timeout_o=1 for 1 cycle.
   - Rerun the same stimulus with done_i asserted on the 4th cycle: timeout_o stays 0.
   - Without the macro: gnt_o=0001 persists for 300 cycles.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin arbiter driving a registered 4:1 mux select
// Optional forced-release timeout is built only when ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       timeout_o
);

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("mux_sel_arbiter: NUM_REQ must be 4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mux_sel_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] hold_q, hold_d;
    logic       release_now;

    // Rotation base: while granted, the current owner becomes the lowest priority.
    logic [1:0] arb_last;
    logic [3:0] rot_req;
    logic [1:0] rot_off;
    logic [1:0] winner;

    always_comb begin
        arb_last = (state_q == GRANT) ? sel_q : last_q;
        for (int k = 0; k < 4; k++) begin
            rot_req[k] = req_i[2'(arb_last + 2'(k) + 2'd1)];
        end
        rot_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) rot_off = 2'(k);
        end
        winner = 2'(arb_last + 2'd1 + rot_off);
    end

`ifdef ARB_TIMEOUT_EN
    logic forced;
    logic to_q, to_d;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
        forced      = 1'b0;
        to_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = 4'(4'b0001 << winner);
                    sel_d   = winner;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                release_now = done_i;
`ifdef ARB_TIMEOUT_EN
                if (!done_i && hold_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    release_now = 1'b1;
                    forced      = 1'b1;
                end
                to_d = forced;
`endif
                if (release_now) begin
                    last_d = sel_q;
                    if (|req_i) begin
                        gnt_d  = 4'(4'b0001 << winner);
                        sel_d  = winner;
                        hold_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) to_q <= 1'b0;
        else     to_q <= to_d;
    end
    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = (state_q == GRANT);

endmodule
